// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the
// I/D cache to memory-port arbiter.
package arbiter_types;
  localparam int S_LINE = 256;
  localparam int S_ADDR = 32;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;
endpackage

// File: rtl/cache_arbiter_if.sv
// Cacheline port bundle: the cache (or arbiter)
// is master, the arbiter (or adaptor) is slave.
interface cache_arbiter_if
  import arbiter_types::*;
#(
  parameter int s_line = S_LINE,
  parameter int s_addr = S_ADDR
);
  logic              pmem_read;
  logic              pmem_write;
  logic [s_addr-1:0] pmem_address;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_rdata,
    input  pmem_resp
  );

  modport slave (
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_rdata,
    output pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one memory port
// between the I-cache and the D-cache.
module cache_arbiter
  import arbiter_types::*;
(
  input logic             clk,
  input logic             rst,
  cache_arbiter_if.slave  i_port,
  cache_arbiter_if.slave  d_port,
  cache_arbiter_if.master mem
);

  arb_state_t        state_q, state_d;
  requester_t        last_q, last_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [S_ADDR-1:0] addr_q, addr_d;
  logic [S_LINE-1:0] wdata_q, wdata_d;

  logic req_i, req_d;
  logic gnt_i, gnt_d;
  logic serve_i, serve_d;

  assign req_i = i_port.pmem_read | i_port.pmem_write;
  assign req_d = d_port.pmem_read | d_port.pmem_write;

  // On conflict the cache not granted last time wins.
  always_comb begin
    gnt_d = req_d & (~req_i | (last_q == REQ_I));
    gnt_i = req_i & ~gnt_d;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt_d: begin
            state_d = SERVE_D;
            last_d  = REQ_D;
            wr_d    = d_port.pmem_write;
            rd_d    = ~d_port.pmem_write;
            addr_d  = d_port.pmem_address;
            wdata_d = d_port.pmem_wdata;
          end
          gnt_i: begin
            state_d = SERVE_I;
            last_d  = REQ_I;
            wr_d    = i_port.pmem_write;
            rd_d    = ~i_port.pmem_write;
            addr_d  = i_port.pmem_address;
            wdata_d = i_port.pmem_wdata;
          end
          default: ;
        endcase
      end
      SERVE_I, SERVE_D: begin
        if (mem.pmem_resp) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= REQ_I;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign serve_i = (state_q == SERVE_I) & mem.pmem_resp;
  assign serve_d = (state_q == SERVE_D) & mem.pmem_resp;

  assign i_port.pmem_resp  = serve_i;
  assign i_port.pmem_rdata = serve_i ? mem.pmem_rdata : '0;
  assign d_port.pmem_resp  = serve_d;
  assign d_port.pmem_rdata = serve_d ? mem.pmem_rdata : '0;

  assign mem.pmem_read    = rd_q;
  assign mem.pmem_write   = wr_q;
  assign mem.pmem_address = addr_q;
  assign mem.pmem_wdata   = wdata_q;

  a_i_no_write: assert property (
    @(posedge clk) disable iff (rst)
    !i_port.pmem_write);

  a_d_one_op: assert property (
    @(posedge clk) disable iff (rst)
    !(d_port.pmem_read && d_port.pmem_write));

  a_mem_one_op: assert property (
    @(posedge clk) disable iff (rst)
    !(rd_q && wr_q));

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized scoreboard bench for cache_arbiter
// against a transaction-level arbitration model.
module tb_cache_arbiter;
  import arbiter_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_arbiter_if ibus ();
  cache_arbiter_if dbus ();
  cache_arbiter_if mbus ();

  cache_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .i_port (ibus),
    .d_port (dbus),
    .mem    (mbus)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [255:0] wdata;
    int          cyc;
  } mem_txn_t;

  typedef struct {
    bit           d;
    logic [255:0] rdata;
    int           cyc;
  } resp_t;

  localparam int NEVER = 32'h7fff_ffff;

  mem_txn_t exp_mem[$];
  resp_t    exp_rsp[$];
  bit       obs_who[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 0;

  // arbitration model
  bit busy, cur_d, last_d;
  int resp_cyc, free_cyc;
  int n_grants;
  int force_lat = -1;
  bit force_rd_en;
  logic [255:0] force_rdata;
  int rate;
  bit chaos, stray_now;

  // cache models
  bit           ireq, dreq, dwr;
  logic [31:0]  iaddr, daddr;
  logic [255:0] iwdata, dwdata;
  int iblk, dblk, idrop, ddrop;

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++)
      v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h",
               name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: actual none required event",
             name);
  endtask

  task automatic drive();
    ibus.pmem_read    = ireq;
    ibus.pmem_write   = 1'b0;
    ibus.pmem_address = iaddr;
    ibus.pmem_wdata   = iwdata;
    dbus.pmem_read    = dreq & ~dwr;
    dbus.pmem_write   = dreq & dwr;
    dbus.pmem_address = daddr;
    dbus.pmem_wdata   = dwdata;
  endtask

  task automatic model_reset();
    busy = 0; cur_d = 0; last_d = 0;
    free_cyc = cyc; n_grants = 0;
    ireq = 0; dreq = 0; dwr = 0;
    iaddr = '0; daddr = '0;
    iwdata = '0; dwdata = '0;
    iblk = 0; dblk = 0;
    idrop = -1; ddrop = -1;
    exp_mem.delete();
    exp_rsp.delete();
  endtask

  task automatic tick();
    logic [255:0] rd;
    logic [255:0] mrd;
    bit mr;
    bit pick_d;
    int lat;
    @(posedge clk);
    #1;
    cyc++;
    mr = 0;
    mrd = '0;
    if (busy && cyc == resp_cyc) begin
      rd = force_rd_en ? force_rdata : rnd_line();
      mr = 1;
      mrd = rd;
      exp_rsp.push_back('{cur_d, rd, cyc});
      busy = 0;
      free_cyc = cyc + 2;
      if (cur_d) begin
        ddrop = cyc + 1; dblk = cyc + 2;
      end else begin
        idrop = cyc + 1; iblk = cyc + 2;
      end
    end else if (!busy &&
                 (stray_now ||
                  (chaos && $urandom_range(0, 99) < 15))) begin
      mr = 1;
      mrd = rnd_line();
    end
    stray_now = 0;
    if (cyc == idrop) ireq = 0;
    if (cyc == ddrop) dreq = 0;
    if (busy && chaos) begin
      if (cur_d && dreq && $urandom_range(0, 99) < 20)
        daddr = 32'hFFFF_FFFF;
      if ($urandom_range(0, 99) < 8) begin
        if (cur_d) begin
          dreq = 0; dblk = NEVER;
        end else begin
          ireq = 0; iblk = NEVER;
        end
      end
    end
    if (rate > 0) begin
      if (!ireq && cyc >= iblk &&
          $urandom_range(0, 99) < rate) begin
        ireq = 1;
        iaddr = $urandom() & 32'hFFFF_FFE0;
        iwdata = rnd_line();
      end
      if (!dreq && cyc >= dblk &&
          $urandom_range(0, 99) < rate) begin
        dreq = 1;
        dwr = $urandom_range(0, 1) == 1;
        daddr = $urandom() & 32'hFFFF_FFE0;
        dwdata = rnd_line();
      end
    end
    // One request per line; on a tie alternate.
    if (!busy && cyc >= free_cyc && (ireq || dreq)) begin
      pick_d = dreq && (!ireq || !last_d);
      last_d = pick_d;
      if (pick_d)
        exp_mem.push_back('{dwr, daddr, dwdata, cyc + 1});
      else
        exp_mem.push_back('{1'b0, iaddr, iwdata, cyc + 1});
      lat = (force_lat >= 0) ? force_lat
                             : $urandom_range(0, 8);
      resp_cyc = cyc + 1 + lat;
      busy = 1;
      cur_d = pick_d;
      n_grants++;
    end
    drive();
    mbus.pmem_resp  = mr;
    mbus.pmem_rdata = mrd;
  endtask

  function automatic bit quiet();
    return !busy && exp_mem.size() == 0 &&
           exp_rsp.size() == 0 && !ireq && !dreq &&
           cyc >= free_cyc;
  endfunction

  task automatic drain(input int budget,
                       input string name);
    int n = 0;
    while (n < budget && !quiet()) begin
      tick();
      n++;
    end
    if (!quiet()) fail_now(name);
  endtask

  // monitor / scoreboard
  bit           m_act, prev_act;
  logic [31:0]  cur_addr;
  mem_txn_t     mt;
  resp_t        rt;

  always @(negedge clk) begin
    if (mon_en) begin
      m_act = mbus.pmem_read | mbus.pmem_write;
      if (mbus.pmem_read && mbus.pmem_write)
        fail_now("mem_rw_exclusive");
      if (m_act && !prev_act) begin
        if (exp_mem.size() == 0) begin
          fail_now("mem_unexpected_req");
        end else begin
          mt = exp_mem.pop_front();
          check("mem_start_cycle", cyc, mt.cyc);
          check("mem_write", mbus.pmem_write, mt.wr);
          check("mem_read", mbus.pmem_read, !mt.wr);
          check("mem_address", mbus.pmem_address,
                mt.addr);
          check("mem_wdata", mbus.pmem_wdata, mt.wdata);
          cur_addr = mt.addr;
        end
      end else if (m_act) begin
        check("mem_addr_hold", mbus.pmem_address,
              cur_addr);
      end
      if (!m_act && exp_mem.size() > 0 &&
          exp_mem[0].cyc <= cyc) begin
        fail_now("mem_missing_req");
        void'(exp_mem.pop_front());
      end
      if (ibus.pmem_resp && dbus.pmem_resp)
        fail_now("resp_exclusive");
      if (ibus.pmem_resp || dbus.pmem_resp) begin
        obs_who.push_back(dbus.pmem_resp);
        if (exp_rsp.size() == 0) begin
          fail_now("resp_unexpected");
        end else begin
          rt = exp_rsp.pop_front();
          check("resp_cycle", cyc, rt.cyc);
          check("resp_to_d", dbus.pmem_resp, rt.d);
          if (rt.d) begin
            check("d_rdata", dbus.pmem_rdata, rt.rdata);
            check("i_rdata_idle", ibus.pmem_rdata, '0);
          end else begin
            check("i_rdata", ibus.pmem_rdata, rt.rdata);
            check("d_rdata_idle", dbus.pmem_rdata, '0);
          end
        end
      end else if (exp_rsp.size() > 0 &&
                   exp_rsp[0].cyc <= cyc) begin
        fail_now("resp_missing");
        void'(exp_rsp.pop_front());
      end
      prev_act = m_act;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] a5;
    logic [255:0] w12;
    int tgt, n;
    a5 = {32{8'hA5}};
    w12 = {8{32'h1234_5678}};
    rate = 0; chaos = 0; stray_now = 0;
    force_rd_en = 0; force_rdata = '0;
    prev_act = 0;
    model_reset();
    ireq = 1; dreq = 1; dwr = 1;
    drive();
    mbus.pmem_resp  = 1'b1;
    mbus.pmem_rdata = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", mbus.pmem_read, 0);
    check("rst_mem_write", mbus.pmem_write, 0);
    check("rst_mem_address", mbus.pmem_address, 0);
    check("rst_mem_wdata", mbus.pmem_wdata, 0);
    check("rst_i_resp", ibus.pmem_resp, 0);
    check("rst_d_resp", dbus.pmem_resp, 0);
    check("rst_i_rdata", ibus.pmem_rdata, 0);
    check("rst_d_rdata", dbus.pmem_rdata, 0);
    @(posedge clk);
    #1;
    cyc = 0;
    model_reset();
    drive();
    mbus.pmem_resp  = 1'b0;
    mbus.pmem_rdata = '0;
    rst = 0;
    mon_en = 1;

    // conflict after reset, D write wins
    obs_who.delete();
    ireq = 1; iaddr = 32'h60; iwdata = rnd_line();
    dreq = 1; dwr = 1; daddr = 32'h8088;
    dwdata = w12;
    force_lat = 4;
    tick();
    tick();
    tick();
    daddr = 32'hFFFF_FFFF;
    drain(100, "t2_drain");
    check("t2_first_is_d", obs_who[0], 1);
    check("t2_second_is_i", obs_who[1], 0);

    // both streaming: D, I, D, I, D, I
    obs_who.delete();
    force_lat = -1;
    rate = 100;
    tgt = n_grants + 6;
    n = 0;
    while (n_grants < tgt && n < 300) begin
      tick();
      n++;
    end
    rate = 0;
    drain(200, "t3_drain");
    for (int k = 0; k < 6; k++) begin
      if (k < obs_who.size())
        check($sformatf("t3_grant%0d", k),
              obs_who[k], (k % 2) == 0);
      else
        fail_now($sformatf("t3_grant%0d", k));
    end

    // lone D read, fixed line and latency
    dreq = 1; dwr = 0; daddr = 32'h0000_8080;
    dwdata = rnd_line();
    force_lat = 7;
    force_rd_en = 1; force_rdata = a5;
    tick();
    drain(100, "t1_drain");
    force_rd_en = 0;
    force_lat = -1;

    // stray mem_resp while idle
    repeat (3) tick();
    stray_now = 1;
    tick();
    repeat (2) tick();
    dreq = 1; dwr = 0; daddr = 32'h0000_4000;
    tick();
    drain(100, "t6_drain");

    // async reset three cycles into SERVE_I
    ireq = 1; iaddr = 32'h0000_0100;
    force_lat = 10;
    tick();
    repeat (3) tick();
    #1;
    rst = 1;
    #1;
    check("t5_async_mem_read", mbus.pmem_read, 0);
    check("t5_async_mem_addr", mbus.pmem_address, 0);
    mon_en = 0;
    model_reset();
    drive();
    mbus.pmem_resp = 1'b0;
    mbus.pmem_rdata = '0;
    prev_act = 0;
    #1;
    rst = 0;
    mon_en = 1;
    force_lat = -1;
    obs_who.delete();
    ireq = 1; iaddr = 32'h0000_0200;
    dreq = 1; dwr = 0; daddr = 32'h0000_0300;
    tick();
    drain(100, "t5_drain");
    if (obs_who.size() > 0)
      check("t5_conflict_to_d", obs_who[0], 1);
    else
      fail_now("t5_conflict_to_d");

    // random traffic with drops, strays, scrambles
    rate = 30;
    chaos = 1;
    repeat (1500) tick();
    rate = 0;
    chaos = 0;
    drain(300, "rand_drain");
    tick();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
